// File: rtl/jpeg_bit_packer.sv
// rtl/jpeg_bit_packer.sv - packs variable-length codes MSB-first into bytes and buffers whole frames in a FIFO
// Optional 0xFF->0xFF,0x00 byte stuffing is built when JPEG_BYTE_STUFF_EN is defined.
module jpeg_bit_packer #(
    parameter int FIFO_DEPTH = 2048
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [26:0] vlc_bits,
    input  logic [4:0]  vlc_len,
    input  logic        vlc_valid,
    input  logic        vlc_last,
    output logic        vlc_ready,
    output logic        Compress_data_rdy,
    input  logic        Compress_data_rden,
    output logic [7:0]  Compress_data,
    output logic        Compress_data_last
);

    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef JPEG_BYTE_STUFF_EN
    localparam bit STUFF_EN = 1'b1;
`else
    localparam bit STUFF_EN = 1'b0;
`endif

    typedef enum logic [1:0] {ACC, STUFF, FLUSH, DONE} state_t;

    state_t      state, state_nx;
    logic [33:0] acc, acc_nx;
    logic [5:0]  fill, fill_nx;
    logic        flushing, flushing_nx;
    logic        frame_bytes, frame_bytes_nx;
    logic [7:0]  last_byte;

    logic [8:0]    mem [0:FIFO_DEPTH-1];
    logic [AW-1:0] wr_ptr, rd_ptr, wr_prev;
    logic [AW:0]   count;
    logic          full, empty, pop, rd_last;
    logic          wr_en, wr_last, mark_en;
    logic [7:0]    wr_data, pad_byte;

    logic [26:0] vlc_mask;
    logic [33:0] vlc_ext;
    logic [5:0]  vlc_shift;

    assign full     = (count == FIFO_DEPTH[AW:0]);
    assign empty    = (count == '0);
    assign pop      = Compress_data_rden && !empty;
    assign rd_last  = mem[rd_ptr][8];
    assign wr_prev  = wr_ptr - AW'(1);
    assign Compress_data_rdy = (state == DONE);

    // New bits land directly below the current fill; bits below the fill stay zero.
    assign vlc_mask  = (27'h1 << vlc_len) - 27'h1;
    assign vlc_ext   = {7'b0, vlc_bits & vlc_mask};
    assign vlc_shift = 6'd34 - fill - {1'b0, vlc_len};
    assign pad_byte  = acc[33:26] | (8'hFF >> fill);

    always_comb begin
        state_nx       = state;
        acc_nx         = acc;
        fill_nx        = fill;
        flushing_nx    = flushing;
        frame_bytes_nx = frame_bytes;
        wr_en          = 1'b0;
        wr_data        = acc[33:26];
        wr_last        = 1'b0;
        mark_en        = 1'b0;
        vlc_ready      = 1'b0;
        case (state)
            ACC: begin
                vlc_ready = rst_n && (fill < 6'd8) && !full;
                if (vlc_valid && vlc_ready) begin
                    acc_nx  = acc | (vlc_ext << vlc_shift);
                    fill_nx = fill + {1'b0, vlc_len};
                    if (vlc_last) begin
                        state_nx    = FLUSH;
                        flushing_nx = 1'b1;
                    end
                end else if (fill >= 6'd8 && !full) begin
                    wr_en   = 1'b1;
                    acc_nx  = acc << 8;
                    fill_nx = fill - 6'd8;
                    if (STUFF_EN && wr_data == 8'hFF)
                        state_nx = STUFF;
                end
            end
            STUFF: begin
                if (!full) begin
                    wr_en    = 1'b1;
                    wr_data  = 8'h00;
                    state_nx = flushing ? FLUSH : ACC;
                end
            end
            FLUSH: begin
                if (fill >= 6'd8) begin
                    if (!full) begin
                        wr_en   = 1'b1;
                        acc_nx  = acc << 8;
                        fill_nx = fill - 6'd8;
                        if (STUFF_EN && wr_data == 8'hFF)
                            state_nx = STUFF;
                    end
                end else if (fill != 6'd0) begin
                    if (!full) begin
                        wr_en   = 1'b1;
                        wr_data = pad_byte;
                        acc_nx  = '0;
                        fill_nx = '0;
                        if (STUFF_EN && pad_byte == 8'hFF) begin
                            state_nx = STUFF;
                        end else begin
                            wr_last     = 1'b1;
                            state_nx    = DONE;
                            flushing_nx = 1'b0;
                        end
                    end
                end else begin
                    // Frame ended on a byte boundary: retro-mark the byte already queued.
                    flushing_nx = 1'b0;
                    if (frame_bytes) begin
                        mark_en  = 1'b1;
                        state_nx = DONE;
                    end else begin
                        state_nx = ACC;
                    end
                end
            end
            DONE: begin
                if (pop && rd_last) begin
                    state_nx       = ACC;
                    frame_bytes_nx = 1'b0;
                end
            end
            default: state_nx = ACC;
        endcase
        if (wr_en)
            frame_bytes_nx = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state              <= ACC;
            acc                <= '0;
            fill               <= '0;
            flushing           <= 1'b0;
            frame_bytes        <= 1'b0;
            last_byte          <= 8'h00;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            count              <= '0;
            Compress_data      <= 8'h00;
            Compress_data_last <= 1'b0;
        end else begin
            state       <= state_nx;
            acc         <= acc_nx;
            fill        <= fill_nx;
            flushing    <= flushing_nx;
            frame_bytes <= frame_bytes_nx;
            if (wr_en) begin
                wr_ptr    <= wr_ptr + AW'(1);
                last_byte <= wr_data;
            end
            if (pop) begin
                rd_ptr             <= rd_ptr + AW'(1);
                Compress_data      <= mem[rd_ptr][7:0];
                Compress_data_last <= rd_last;
            end
            count <= count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (wr_en)
                mem[wr_ptr] <= {wr_last, wr_data};
            else if (mark_en)
                mem[wr_prev] <= {1'b1, last_byte};
        end
    end

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// tb/tb_jpeg_bit_packer.sv - scoreboard bench for jpeg_bit_packer with a bit-level packing model
module tb_jpeg_bit_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [26:0] vlc_bits;
    logic [4:0]  vlc_len;
    logic        vlc_valid;
    logic        vlc_last;
    logic        vlc_ready;
    logic        Compress_data_rdy;
    logic        Compress_data_rden;
    logic [7:0]  Compress_data;
    logic        Compress_data_last;

    int n_tests = 0;
    int n_fails = 0;

    logic [8:0] exp_q[$];
    bit         bitq[$];
    int         frame_n = 0;

    jpeg_bit_packer #(.FIFO_DEPTH(16)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .vlc_bits           (vlc_bits),
        .vlc_len            (vlc_len),
        .vlc_valid          (vlc_valid),
        .vlc_last           (vlc_last),
        .vlc_ready          (vlc_ready),
        .Compress_data_rdy  (Compress_data_rdy),
        .Compress_data_rden (Compress_data_rden),
        .Compress_data      (Compress_data),
        .Compress_data_last (Compress_data_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_emit(input logic [7:0] b);
        exp_q.push_back({1'b0, b});
        frame_n++;
`ifdef JPEG_BYTE_STUFF_EN
        if (b == 8'hFF) begin
            exp_q.push_back(9'h000);
            frame_n++;
        end
`endif
    endtask

    task automatic model_add(input logic [26:0] bits, input int len, input bit last);
        logic [7:0] b;
        for (int i = len - 1; i >= 0; i--)
            bitq.push_back(bits[i]);
        while (bitq.size() >= 8) begin
            b = 8'h00;
            for (int k = 0; k < 8; k++) b = {b[6:0], bitq.pop_front()};
            model_emit(b);
        end
        if (last) begin
            if (bitq.size() > 0) begin
                b = 8'h00;
                for (int k = 0; k < 8; k++)
                    b = {b[6:0], (bitq.size() > 0) ? bitq.pop_front() : 1'b1};
                model_emit(b);
            end
            if (frame_n > 0)
                exp_q[exp_q.size()-1][8] = 1'b1;
            frame_n = 0;
        end
    endtask

    task automatic send(input logic [26:0] bits, input int len, input bit last);
        bit ok = 0;
        @(negedge clk);
        vlc_bits  = bits;
        vlc_len   = len[4:0];
        vlc_last  = last;
        vlc_valid = 1'b1;
        for (int c = 0; c < 500; c++) begin
            if (vlc_ready) begin
                @(posedge clk);
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        #1;
        vlc_valid = 1'b0;
        vlc_last  = 1'b0;
        if (ok) model_add(bits, len, last);
        else    chk("accept_timeout", 0, 1);
    endtask

    task automatic pop_check(input string tag);
        logic [8:0] e;
        @(negedge clk);
        Compress_data_rden = 1'b1;
        @(negedge clk);
        Compress_data_rden = 1'b0;
        if (exp_q.size() == 0) begin
            chk({tag, "_unexpected"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, Compress_data, e[7:0]);
            chk({tag, "_last"}, Compress_data_last, e[8]);
        end
    endtask

    task automatic empty_pop(input string tag, input logic [7:0] d, input logic l);
        @(negedge clk);
        Compress_data_rden = 1'b1;
        @(negedge clk);
        Compress_data_rden = 1'b0;
        chk({tag, "_data"}, Compress_data, d);
        chk({tag, "_last"}, Compress_data_last, l);
    endtask

    task automatic drain(input string tag);
        bit seen = 0;
        int n;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (Compress_data_rdy) begin
                seen = 1;
                break;
            end
        end
        chk({tag, "_rdy_rise"}, seen, 1);
        n = exp_q.size();
        for (int i = 0; i < n; i++) pop_check(tag);
        chk({tag, "_rdy_fall"}, Compress_data_rdy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        vlc_bits = '0;
        vlc_len = '0;
        vlc_valid = 1'b0;
        vlc_last = 1'b0;
        Compress_data_rden = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_vlc_ready", vlc_ready, 0);
        chk("rst_rdy", Compress_data_rdy, 0);
        chk("rst_data", Compress_data, 8'h00);
        chk("rst_last", Compress_data_last, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", vlc_ready, 1);

        // two-byte frame with padding
        send(27'hAB, 8, 0);
        send(27'hC, 4, 1);
        drain("ab_c");

        // single partial byte
        send(27'h2, 3, 1);
        drain("short");

        // 0xFF handling
        send(27'hFF, 8, 0);
        send(27'h12, 8, 1);
        drain("ff");

        // FIFO fills and stalls the input, then everything pops in order
        for (int i = 0; i < 16; i++) send(27'(8'h10 + i), 8, 0);
        repeat (4) @(negedge clk);
        chk("full_stall_ready", vlc_ready, 0);
        fork
            begin
                for (int i = 16; i < 20; i++) send(27'(8'h10 + i), 8, i == 19);
            end
            begin
                for (int i = 0; i < 16; i++) pop_check("full");
            end
        join
        drain("full_tail");

        // reset in the middle of a frame discards it
        for (int i = 0; i < 5; i++) send(27'(8'h21 + i), 8, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_rdy", Compress_data_rdy, 0);
        chk("midrst_data", Compress_data, 8'h00);
        chk("midrst_ready", vlc_ready, 0);
        rst_n = 1'b1;
        exp_q.delete();
        bitq.delete();
        frame_n = 0;
        @(negedge clk);
        chk("midrst_ready_back", vlc_ready, 1);
        empty_pop("midrst_empty", 8'h00, 1'b0);
        send(27'h31, 8, 0);
        send(27'h32, 8, 1);
        drain("after_rst");
        empty_pop("hold_after_drain", 8'h32, 1'b1);

        // empty frame
        send(27'h0, 0, 1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (Compress_data_rdy) chk("empty_frame_rdy", 1, 0);
        end
        chk("empty_frame_ready", vlc_ready, 1);
        chk("empty_frame_queue", exp_q.size(), 0);

        // random frames with unmasked garbage above vlc_len
        for (int f = 0; f < 8; f++) begin
            int nsym;
            nsym = $urandom_range(1, 2);
            for (int s = 0; s < nsym; s++) begin
                logic [26:0] bits;
                bits = ($urandom_range(0, 2) == 0) ? 27'h7FFFFFF : 27'($urandom);
                send(bits, $urandom_range(0, 27), s == nsym - 1);
            end
            if (exp_q.size() > 0) begin
                drain("rand");
            end else begin
                repeat (5) @(negedge clk);
                chk("rand_empty_rdy", Compress_data_rdy, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule

// File: doc/jpeg_bit_packer.md
JPEG_BIT_PACKER -- requirements
Module: jpeg_bit_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2048, byte capacity of output FIFO (power of two, >=16).
REQ-002 SHALL have clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have vlc_bits  input  27  Huffman code plus magnitude bits, right-aligned; bit [vlc_len-1] sent first.
REQ-005 SHALL have vlc_len  input  5  number of valid bits, 0..27; 0 = no bits, only vlc_last is honoured.
REQ-006 SHALL have vlc_valid  input  1  symbol present.
REQ-007 SHALL have vlc_last  input  1  final symbol of the frame's scan.
REQ-008 SHALL have vlc_ready  output  1  symbol accepted when vlc_valid & vlc_ready.
REQ-009 SHALL have Compress_data_rdy  output  1  a complete frame is buffered.
REQ-010 SHALL have Compress_data_rden  input  1  pop request.
REQ-011 SHALL have Compress_data  output  8  popped byte.
REQ-012 SHALL have Compress_data_last  output  1  marks final byte of frame.

Function
REQ-013 SHALL hold bits in a 34-bit MSB-first accumulator with a 6-bit fill count (max 7+27=34).
REQ-014 SHALL assert vlc_ready only in state ACC, with fill < 8 and Compress_data_rdy low.
REQ-015 SHALL, in ACC with fill >= 8 and FIFO not full, write the top accumulator byte into the FIFO and subtract 8 from fill, one byte per cycle.
REQ-016 SHALL, after writing byte 0xFF, enter STUFF and write 0x00 next cycle when FIFO not full, then return to ACC.
REQ-017 SHALL, on accepted vlc_last, enter FLUSH after its bits are appended; drain whole bytes as in ACC; pad a partial final byte (fill 1..7) with 1s in the LSBs and write it, marked last.
REQ-018 SHALL, if fill is 0 at the end of FLUSH, mark the last byte already written (or the stuffed 0x00) as last; an empty frame writes no bytes and raises no rdy.
REQ-019 SHALL stall writes, with no loss or duplication, while the FIFO is full; vlc_ready stays low.
REQ-020 SHALL go to DONE after the last byte is written, raise Compress_data_rdy the next cycle, and hold it until the last-marked byte is popped.
REQ-021 SHALL return from DONE to ACC in the cycle after the last byte is popped.
REQ-022 SHALL, when Compress_data_rden is high and FIFO non-empty, pop and present the byte on Compress_data the next cycle, with Compress_data_last set for the marked byte; rden on empty FIFO is ignored and outputs hold.
REQ-023 SHALL permit simultaneous FIFO write and pop in one cycle; occupancy unchanged.
REQ-024 SHALL store the last flag as a 9th FIFO bit.

Reset
REQ-025 SHALL, while rst_n low at a clock edge, clear accumulator, fill, FIFO pointers and occupancy, go to ACC, and drive vlc_ready=0, Compress_data_rdy=0, Compress_data=0x00, Compress_data_last=0.
REQ-026 SHALL discard any partial frame on reset mid-operation; no byte from it is popped afterwards.
REQ-027 SHALL assert vlc_ready in the first cycle after rst_n returns high.

Configuration
REQ-028 SHALL, with macro JPEG_BYTE_STUFF_EN defined, perform 0xFF->0xFF,0x00 stuffing per REQ-016.
REQ-029 SHALL, without JPEG_BYTE_STUFF_EN, omit STUFF entirely and write 0xFF unchanged.

Verification
REQ-030 SHALL cover: vlc 0xAB/len 8, then 0xC/len 4 with last -> pops AB, CF; last on CF; rdy falls after CF popped.
REQ-031 SHALL cover: 3'b010/len 3 with last -> single byte 0x5F, last=1.
REQ-032 SHALL cover: 0xFF/len 8, 0x12/len 8 with last, stuffing on -> FF, 00, 12; macro off -> FF, 12.
REQ-033 SHALL cover: FIFO_DEPTH=16, 20 bytes of len-8 symbols with rden held low -> vlc_ready low after 16 writes; then pops return all 20 bytes in order.
REQ-034 SHALL cover: reset after 5 of 10 bytes written -> rdy=0, FIFO empty; a new 2-byte frame then pops exactly those 2 bytes.
REQ-035 SHALL cover: vlc_len 0 with last, fill=0 -> no bytes, rdy stays low, vlc_ready returns high.
